axi_slave_ram: RTL and testbench
================================

// Module: axi_slave_ram
// PURPOSE
//  AXI4 responder (slave) with an internal byte-addressable RAM. It is the far end of the 128-bit
//  AXI4 master driven by the DPI TCP bridge, so host-issued reads and writes complete in simulation
//  without external memory. Read and write channels are independent; each allows one outstanding burst.
// PARAMETERS
//  DATA_W      128    data width in bits; strb width = DATA_W/8
//  ADDR_W      32     AXI address width
//  DEPTH_WORDS 4096   RAM depth in DATA_W words; byte window = DEPTH_WORDS*DATA_W/8 from BASE_ADDR
//  BASE_ADDR   32'h0  first byte address decoded by the RAM
// PORTS
//  clk                          in   1        clock, all logic on posedge
//  reset                        in   1        asynchronous, active-low
//  slaveAxi_aw_valid/_ready     in/out 1      write address handshake
//  slaveAxi_aw_payload_addr     in   ADDR_W   burst start byte address
//  slaveAxi_aw_payload_len      in   8        beats-1
//  slaveAxi_aw_payload_size     in   3        log2 bytes per beat
//  slaveAxi_aw_payload_burst    in   2        00 FIXED, 01 INCR, 10 WRAP
//  slaveAxi_w_valid/_ready      in/out 1      write data handshake
//  slaveAxi_w_payload_data      in   DATA_W   write data
//  slaveAxi_w_payload_strb      in   DATA_W/8 byte enables
//  slaveAxi_w_payload_last      in   1        final beat marker
//  slaveAxi_b_valid/_ready      out/in 1      write response handshake
//  slaveAxi_b_payload_resp      out  2        00 OKAY, 10 SLVERR
//  slaveAxi_ar_valid/_ready     in/out 1      read address handshake; addr/len/size/burst as AW
//  slaveAxi_r_valid/_ready      out/in 1      read data handshake
//  slaveAxi_r_payload_data      out  DATA_W   read data
//  slaveAxi_r_payload_resp      out  2        per-beat response
//  slaveAxi_r_payload_last      out  1        final beat marker
// BEHAVIOUR
//  - Reset (reset==0): all *_valid, *_ready and last = 0; resp = 00; data = 0; FSMs in IDLE.
//    A registered alive flag keeps aw/ar_ready at 0 for the first cycle after reset deassertion.
//  - Handshake: a transfer occurs on the posedge where valid&&ready. Once asserted, an output valid
//    and its payload hold until that handshake.
//  - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE.
//    W_IDLE: aw_ready=1; on the AW handshake latch addr/len/size/burst, beat_cnt=0, err=0.
//    W_DATA: w_ready=1; each beat writes the bytes whose strb bit is 1 into word (addr-BASE)>>4.
//    W_DATA exits after exactly len+1 beats; beat count, not w_last, decides the exit.
//    W_RESP: b_valid=1 with resp = err ? 10 : 00; on the B handshake go to W_IDLE.
//  - Read FSM R_IDLE->R_FETCH->R_DATA.
//    R_IDLE: ar_ready=1; latch the request on the AR handshake.
//    R_FETCH: one-cycle synchronous RAM read.
//    R_DATA: r_valid=1; r_last=(beat_cnt==len). On the handshake: if last, go to R_IDLE; else advance
//    the address and go to R_FETCH. Throughput is 1 beat per 2 cycles; AR-to-first-r_valid is 2 cycles.
//  - Address advance: INCR/WRAP: addr = (addr & ~((1<<size)-1)) + (1<<size). FIXED: addr unchanged.
//    Arithmetic is ADDR_W bits, modulo 2^ADDR_W.
//  - Errors produce SLVERR; an erroring write beat is discarded and an erroring read beat returns data 0.
//    Error conditions: size>log2(DATA_W/8); burst==WRAP; beat address outside the window; on writes,
//    w_last value != (beat_cnt==len). Error is sticky per write burst and reported per beat on reads.
//  - Write-then-read collision on one word in one cycle: the read returns the old data.
//    The write lands at that edge.
//  - Reset asserted mid-burst aborts both FSMs immediately; RAM contents are not cleared.
// STRUCTURE
//  - axi_pkg: resp codes (RESP_OKAY, RESP_SLVERR), burst codes, w_state_e and r_state_e enums,
//    and the function next_addr(addr, size, burst).
//  - Sub-module axi_slave_ram_mem: simple dual-port RAM (1 write port with byte enables, 1 synchronous
//    read port), DEPTH_WORDS x DATA_W.
// TESTING
//  1 Single write: AW addr 0x10, len 0, size 4, INCR; W data 0x0123..EF, strb 0xFFFF, last 1
//    -> one B response with resp 00; a later single read of 0x10 returns the same data with r_last 1.
//  2 INCR burst: write len 3 from 0x100 with data k=0..3; read back len 3
//    -> 4 R beats in order, r_last only on beat 3, all resp 00.
//  3 Partial strobe: word 0x200 preloaded with all-ones; write data 0, strb 0x00FF; read back
//    -> data 0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000.
//  4 Errors: write to BASE+DEPTH_WORDS*16 -> B resp 10 and RAM unchanged;
//    read burst of 2 starting at the last word -> beat0 resp 00, beat1 resp 10 with data 0.
//  5 Backpressure and overlap: b_ready=0 for 5 cycles, r_ready toggled randomly, concurrent AW/AR
//    -> b_valid and r payload stable until the handshake; no beat lost or duplicated.
//  6 Reset mid write burst, after beat 1 of 4 -> all valids 0; FSMs return to IDLE;
//    beat 0 persists in RAM; the next transaction completes normally.

Source files
------------

// File: rtl/axi_slave_ram_pkg.sv
// Shared types for the AXI4 slave RAM: response and burst codes,
// channel FSM state enums and the burst address-advance helper.
package axi_slave_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_e;

    // Next beat address; callers truncate to their own address width,
    // which keeps the arithmetic modulo 2^ADDR_W.
    function automatic logic [63:0] next_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        step = 64'd1 << size;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else begin
            next_addr = (addr & ~(step - 64'd1)) + step;
        end
    endfunction

endpackage

// File: rtl/axi_slave_ram_if.sv
// AXI4 bus bundle between a master and the slave RAM.
// Ports: AW/W/B write channels, AR/R read channels; master/slave modports.
interface axi_slave_ram_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
);

    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_W-1:0]     aw_payload_addr;
    logic [7:0]            aw_payload_len;
    logic [2:0]            aw_payload_size;
    logic [1:0]            aw_payload_burst;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_W-1:0]     w_payload_data;
    logic [DATA_W/8-1:0]   w_payload_strb;
    logic                  w_payload_last;

    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_payload_resp;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_W-1:0]     ar_payload_addr;
    logic [7:0]            ar_payload_len;
    logic [2:0]            ar_payload_size;
    logic [1:0]            ar_payload_burst;

    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_W-1:0]     r_payload_data;
    logic [1:0]            r_payload_resp;
    logic                  r_payload_last;

    modport master (
        output aw_valid, aw_payload_addr, aw_payload_len,
        output aw_payload_size, aw_payload_burst,
        input  aw_ready,
        output w_valid, w_payload_data, w_payload_strb, w_payload_last,
        input  w_ready,
        input  b_valid, b_payload_resp,
        output b_ready,
        output ar_valid, ar_payload_addr, ar_payload_len,
        output ar_payload_size, ar_payload_burst,
        input  ar_ready,
        input  r_valid, r_payload_data, r_payload_resp, r_payload_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_payload_addr, aw_payload_len,
        input  aw_payload_size, aw_payload_burst,
        output aw_ready,
        input  w_valid, w_payload_data, w_payload_strb, w_payload_last,
        output w_ready,
        output b_valid, b_payload_resp,
        input  b_ready,
        input  ar_valid, ar_payload_addr, ar_payload_len,
        input  ar_payload_size, ar_payload_burst,
        output ar_ready,
        output r_valid, r_payload_data, r_payload_resp, r_payload_last,
        input  r_ready
    );

endinterface

// File: rtl/axi_slave_ram_mem.sv
// Simple dual-port RAM, DEPTH_WORDS x DATA_W: byte-enabled write port,
// registered read port (clk, we_i/waddr_i/wdata_i/wstrb_i, re_i/raddr_i, rdata_o).
module axi_slave_ram_mem #(
    parameter int DATA_W      = 128,
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Same-word read and write at one edge: the read sees the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave with internal RAM; independent read/write FSMs, one burst each.
// Ports: clk, reset (async, active-low), slaveAxi (AXI4 slave modport).
module axi_slave_ram
    import axi_slave_ram_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic           clk,
    input  logic           reset,
    axi_slave_ram_if.slave slaveAxi
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LG     = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [63:0] WIN_BYTES = 64'(DEPTH_WORDS) * 64'(STRB_W);

    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        // Addresses below BASE wrap to a huge offset and fail the compare.
        off = a - BASE_ADDR;
        return 64'(off) < WIN_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LG);
    endfunction

    function automatic logic [ADDR_W-1:0] advance(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        return ADDR_W'(next_addr(64'(a), size, burst));
    endfunction

    function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'(LG)) || (burst == BURST_WRAP);
    endfunction

    // Holds aw/ar_ready low for the first cycle out of reset.
    logic alive_q;

    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]        aw_len_q, aw_len_d;
    logic [2:0]        aw_size_q, aw_size_d;
    logic [1:0]        aw_burst_q, aw_burst_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              w_beat_err;

    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]        ar_len_q, ar_len_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              r_err_q, r_err_d;

    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  mem_waddr;
    logic [IDX_W-1:0]  mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_q    <= 1'b0;
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
        end else begin
            alive_q    <= 1'b1;
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
        end
    end

    // A beat errs on a bad request, an out-of-window address, or a
    // w_last that disagrees with the beat count.
    assign w_beat_err = cfg_bad(aw_size_q, aw_burst_q)
                      || !in_win(aw_addr_q)
                      || (slaveAxi.w_payload_last != (w_cnt_q == aw_len_q));

    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        w_cnt_d    = w_cnt_q;
        w_err_d    = w_err_q;
        mem_we     = 1'b0;
        slaveAxi.aw_ready       = 1'b0;
        slaveAxi.w_ready        = 1'b0;
        slaveAxi.b_valid        = 1'b0;
        slaveAxi.b_payload_resp = RESP_OKAY;
        unique case (w_state_q)
            W_IDLE: begin
                slaveAxi.aw_ready = alive_q;
                if (alive_q && slaveAxi.aw_valid) begin
                    aw_addr_d  = slaveAxi.aw_payload_addr;
                    aw_len_d   = slaveAxi.aw_payload_len;
                    aw_size_d  = slaveAxi.aw_payload_size;
                    aw_burst_d = slaveAxi.aw_payload_burst;
                    w_cnt_d    = '0;
                    w_err_d    = 1'b0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                slaveAxi.w_ready = 1'b1;
                if (slaveAxi.w_valid) begin
                    mem_we    = !w_beat_err;
                    w_err_d   = w_err_q | w_beat_err;
                    aw_addr_d = advance(aw_addr_q, aw_size_q, aw_burst_q);
                    w_cnt_d   = w_cnt_q + 8'd1;
                    if (w_cnt_q == aw_len_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                slaveAxi.b_valid        = 1'b1;
                slaveAxi.b_payload_resp = w_err_q ? RESP_SLVERR : RESP_OKAY;
                if (slaveAxi.b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt_q    <= '0;
            r_err_q    <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            r_err_q    <= r_err_d;
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_cnt_d    = r_cnt_q;
        r_err_d    = r_err_q;
        mem_re     = 1'b0;
        slaveAxi.ar_ready       = 1'b0;
        slaveAxi.r_valid        = 1'b0;
        slaveAxi.r_payload_data = '0;
        slaveAxi.r_payload_resp = RESP_OKAY;
        slaveAxi.r_payload_last = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                slaveAxi.ar_ready = alive_q;
                if (alive_q && slaveAxi.ar_valid) begin
                    ar_addr_d  = slaveAxi.ar_payload_addr;
                    ar_len_d   = slaveAxi.ar_payload_len;
                    ar_size_d  = slaveAxi.ar_payload_size;
                    ar_burst_d = slaveAxi.ar_payload_burst;
                    r_cnt_d    = '0;
                    r_state_d  = R_FETCH;
                end
            end
            R_FETCH: begin
                mem_re    = 1'b1;
                r_err_d   = cfg_bad(ar_size_q, ar_burst_q) || !in_win(ar_addr_q);
                r_state_d = R_DATA;
            end
            R_DATA: begin
                slaveAxi.r_valid        = 1'b1;
                slaveAxi.r_payload_data = r_err_q ? '0 : mem_rdata;
                slaveAxi.r_payload_resp = r_err_q ? RESP_SLVERR : RESP_OKAY;
                slaveAxi.r_payload_last = (r_cnt_q == ar_len_q);
                if (slaveAxi.r_ready) begin
                    if (r_cnt_q == ar_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        ar_addr_d = advance(ar_addr_q, ar_size_q, ar_burst_q);
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign mem_waddr = word_idx(aw_addr_q);
    assign mem_raddr = word_idx(ar_addr_q);

    axi_slave_ram_mem #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (slaveAxi.w_payload_data),
        .wstrb_i (slaveAxi.w_payload_strb),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi_slave_ram.sv
// Bench for axi_slave_ram: directed and randomized bursts checked
// against a byte-array reference model of the RAM window.
module tb_axi_slave_ram;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [31:0] WIN   = 32'h0001_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0]   mem_m [65536];
    logic [127:0] wd [16];
    logic [15:0]  ws [16];
    logic [127:0] last_rdata;

    always #5 clk = ~clk;

    axi_slave_ram_if #(.DATA_W(128), .ADDR_W(32)) bus ();

    axi_slave_ram #(
        .DATA_W      (128),
        .ADDR_W      (32),
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .slaveAxi (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(
        input logic [31:0] a, input logic [2:0] size,
        input logic [1:0] burst, input int k
    );
        logic [31:0] n;
        n = 32'd1 << size;
        if (k == 0 || burst == FIXED) return a;
        return (a & ~(n - 32'd1)) + n * 32'(k);
    endfunction

    function automatic logic inwin(input logic [31:0] a);
        return a < WIN;
    endfunction

    function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd4) || (burst == WRAP);
    endfunction

    function automatic logic [127:0] model_word(input logic [31:0] a);
        logic [127:0] w;
        for (int b = 0; b < 16; b++) w[b*8 +: 8] = mem_m[{a[15:4], 4'(b)}];
        return w;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
        for (int b = 0; b < 16; b++) begin
            if (s[b]) mem_m[{a[15:4], 4'(b)}] = d[b*8 +: 8];
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " aw_ready"}, 128'(bus.aw_ready), 128'd0);
        chk({tag, " ar_ready"}, 128'(bus.ar_ready), 128'd0);
        chk({tag, " w_ready"}, 128'(bus.w_ready), 128'd0);
        chk({tag, " b_valid"}, 128'(bus.b_valid), 128'd0);
        chk({tag, " r_valid"}, 128'(bus.r_valid), 128'd0);
        chk({tag, " r_last"}, 128'(bus.r_payload_last), 128'd0);
        chk({tag, " b_resp"}, 128'(bus.b_payload_resp), 128'd0);
        chk({tag, " r_resp"}, 128'(bus.r_payload_resp), 128'd0);
        chk({tag, " r_data"}, bus.r_payload_data, 128'd0);
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        bus.aw_payload_addr  = a;
        bus.aw_payload_len   = len;
        bus.aw_payload_size  = size;
        bus.aw_payload_burst = burst;
        bus.aw_valid = 1'b1;
        n = 0;
        while (bus.aw_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("aw_ready", 128'(bus.aw_ready), 128'd1);
        @(negedge clk);
        bus.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [127:0] d, input logic [15:0] s, input logic last);
        int n;
        bus.w_payload_data = d;
        bus.w_payload_strb = s;
        bus.w_payload_last = last;
        bus.w_valid = 1'b1;
        n = 0;
        while (bus.w_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w_ready", 128'(bus.w_ready), 128'd1);
        @(negedge clk);
        bus.w_valid = 1'b0;
    endtask

    task automatic get_b(input logic [1:0] exp, input int hold);
        int n;
        bus.b_ready = 1'b0;
        n = 0;
        while (bus.b_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b_valid", 128'(bus.b_valid), 128'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("b_valid held", 128'(bus.b_valid), 128'd1);
            chk("b_resp held", 128'(bus.b_payload_resp), 128'(exp));
        end
        chk("b_resp", 128'(bus.b_payload_resp), 128'(exp));
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
        chk("b_consumed", 128'(bus.b_valid), 128'd0);
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int hold, input int bad_last);
        logic err;
        logic last;
        logic [31:0] ba;
        send_aw(a, len, size, burst);
        err = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            last = (k == int'(len));
            if (k == bad_last) last = !last;
            send_w(wd[k], ws[k], last);
            ba = beat_addr(a, size, burst, k);
            if (bad_req(size, burst) || !inwin(ba) || last != (k == int'(len))) err = 1'b1;
            else model_write(ba, wd[k], ws[k]);
        end
        get_b(err ? SLVERR : OKAY, hold);
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input bit rnd);
        int k, n;
        logic stall, seen;
        logic [31:0]  ba;
        logic [1:0]   er, sr;
        logic [127:0] ed, sd;
        logic         sl;
        int n_ar;
        bus.ar_payload_addr  = a;
        bus.ar_payload_len   = len;
        bus.ar_payload_size  = size;
        bus.ar_payload_burst = burst;
        bus.ar_valid = 1'b1;
        n_ar = 0;
        while (bus.ar_ready !== 1'b1 && n_ar < 50) begin
            @(negedge clk);
            n_ar++;
        end
        chk("ar_ready", 128'(bus.ar_ready), 128'd1);
        @(negedge clk);
        bus.ar_valid = 1'b0;
        k = 0;
        n = 0;
        stall = 1'b0;
        seen = 1'b0;
        sd = '0;
        sr = '0;
        sl = 1'b0;
        while (k <= int'(len) && n < 400) begin
            bus.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.r_valid === 1'b1) begin
                if (!seen) chk("r_latency", 128'(n), 128'd1);
                seen = 1'b1;
                if (stall) begin
                    chk("r_data stable", bus.r_payload_data, sd);
                    chk("r_resp stable", 128'(bus.r_payload_resp), 128'(sr));
                    chk("r_last stable", 128'(bus.r_payload_last), 128'(sl));
                end
                if (bus.r_ready) begin
                    ba = beat_addr(a, size, burst, k);
                    er = (bad_req(size, burst) || !inwin(ba)) ? SLVERR : OKAY;
                    ed = (er == OKAY) ? model_word(ba) : 128'd0;
                    chk("r_data", bus.r_payload_data, ed);
                    chk("r_resp", 128'(bus.r_payload_resp), 128'(er));
                    chk("r_last", 128'(bus.r_payload_last), 128'(k == int'(len)));
                    last_rdata = bus.r_payload_data;
                    k++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    sd = bus.r_payload_data;
                    sr = bus.r_payload_resp;
                    sl = bus.r_payload_last;
                end
            end
            @(negedge clk);
            n++;
        end
        bus.r_ready = 1'b0;
        chk("r_beats", 128'(k), 128'(int'(len) + 1));
        chk("r_no_extra", 128'(bus.r_valid), 128'd0);
    endtask

    task automatic fill_rand(input int beats, input bit rnd_strb);
        for (int k = 0; k < beats; k++) begin
            wd[k] = {$urandom, $urandom, $urandom, $urandom};
            ws[k] = rnd_strb ? 16'($urandom) : 16'hFFFF;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  wa, ra;
        logic [7:0]   wl, rl;
        logic [2:0]   rs;
        logic [127:0] d0;

        bus.aw_valid = 0; bus.aw_payload_addr = 0; bus.aw_payload_len = 0;
        bus.aw_payload_size = 0; bus.aw_payload_burst = 0;
        bus.w_valid = 0; bus.w_payload_data = 0; bus.w_payload_strb = 0;
        bus.w_payload_last = 0; bus.b_ready = 0;
        bus.ar_valid = 0; bus.ar_payload_addr = 0; bus.ar_payload_len = 0;
        bus.ar_payload_size = 0; bus.ar_payload_burst = 0; bus.r_ready = 0;
        last_rdata = '0;

        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;
        #1;
        chk("alive aw_ready", 128'(bus.aw_ready), 128'd0);
        chk("alive ar_ready", 128'(bus.ar_ready), 128'd0);
        @(negedge clk);
        chk("post-alive aw_ready", 128'(bus.aw_ready), 128'd1);
        chk("post-alive ar_ready", 128'(bus.ar_ready), 128'd1);

        // single write / read
        wd[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
        ws[0] = 16'hFFFF;
        wr_burst(32'h10, 8'd0, 3'd4, INCR, 0, -1);
        rd_burst(32'h10, 8'd0, 3'd4, INCR, 1'b0);
        chk("single readback", last_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);

        // INCR burst of 4
        for (int k = 0; k < 4; k++) begin
            wd[k] = {$urandom, $urandom, $urandom, 32'(k)};
            ws[k] = 16'hFFFF;
        end
        wr_burst(32'h100, 8'd3, 3'd4, INCR, 0, -1);
        rd_burst(32'h100, 8'd3, 3'd4, INCR, 1'b0);

        // FIXED burst: all beats land on one word
        fill_rand(3, 1'b0);
        wr_burst(32'h500, 8'd2, 3'd4, FIXED, 0, -1);
        rd_burst(32'h500, 8'd1, 3'd4, FIXED, 1'b0);

        // partial strobe
        wd[0] = '1;
        ws[0] = 16'hFFFF;
        wr_burst(32'h200, 8'd0, 3'd4, INCR, 0, -1);
        wd[0] = '0;
        ws[0] = 16'h00FF;
        wr_burst(32'h200, 8'd0, 3'd4, INCR, 0, -1);
        rd_burst(32'h200, 8'd0, 3'd4, INCR, 1'b0);
        chk("strobe merge", last_rdata, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);

        // errors: out-of-window write must not alias onto word 0
        fill_rand(1, 1'b0);
        wr_burst(32'h0, 8'd0, 3'd4, INCR, 0, -1);
        fill_rand(1, 1'b0);
        wr_burst(WIN, 8'd0, 3'd4, INCR, 0, -1);
        rd_burst(32'h0, 8'd0, 3'd4, INCR, 1'b0);
        fill_rand(1, 1'b0);
        wr_burst(32'hFFF0, 8'd0, 3'd4, INCR, 0, -1);
        rd_burst(32'hFFF0, 8'd1, 3'd4, INCR, 1'b0);
        fill_rand(16, 1'b0);
        wr_burst(32'h2000, 8'd15, 3'd4, INCR, 0, -1);
        fill_rand(1, 1'b0);
        wr_burst(32'h2000, 8'd0, 3'd4, WRAP, 0, -1);
        rd_burst(32'h2000, 8'd1, 3'd5, INCR, 1'b0);
        rd_burst(32'h2000, 8'd0, 3'd4, WRAP, 1'b0);
        fill_rand(2, 1'b0);
        wr_burst(32'h400, 8'd1, 3'd4, INCR, 0, -1);
        fill_rand(2, 1'b0);
        wr_burst(32'h400, 8'd1, 3'd4, INCR, 0, 0);
        rd_burst(32'h400, 8'd1, 3'd4, INCR, 1'b0);

        // backpressure with concurrent write and read bursts
        fill_rand(16, 1'b0);
        wr_burst(32'h3000, 8'd15, 3'd4, INCR, 0, -1);
        for (int i = 0; i < 6; i++) begin
            wa = 32'h3000 + 32'h10 * 32'($urandom_range(0, 12));
            wl = 8'($urandom_range(0, 3));
            ra = 32'h2000 + 32'h10 * 32'($urandom_range(0, 8));
            rl = 8'($urandom_range(0, 3));
            rs = 3'($urandom_range(2, 4));
            fill_rand(int'(wl) + 1, 1'b1);
            fork
                wr_burst(wa, wl, 3'd4, INCR, 5, -1);
                rd_burst(ra, rl, rs, INCR, 1'b1);
            join
            rd_burst(wa, wl, 3'd4, INCR, 1'b1);
        end

        // reset in the middle of a 4-beat write
        send_aw(32'h300, 8'd3, 3'd4, INCR);
        d0 = {$urandom, $urandom, $urandom, $urandom};
        send_w(d0, 16'hFFFF, 1'b0);
        model_write(32'h300, d0, 16'hFFFF);
        bus.w_payload_data = {$urandom, $urandom, $urandom, $urandom};
        bus.w_payload_last = 1'b0;
        bus.w_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk_idle("mid-burst reset");
        @(negedge clk);
        bus.w_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst alive aw_ready", 128'(bus.aw_ready), 128'd0);
        @(negedge clk);
        chk("rst idle aw_ready", 128'(bus.aw_ready), 128'd1);
        chk("rst idle ar_ready", 128'(bus.ar_ready), 128'd1);
        chk("rst idle w_ready", 128'(bus.w_ready), 128'd0);
        rd_burst(32'h300, 8'd0, 3'd4, INCR, 1'b0);
        chk("beat0 persists", last_rdata, d0);
        fill_rand(2, 1'b1);
        ws[0] = 16'hFFFF;
        ws[1] = 16'hFFFF;
        wr_burst(32'h300, 8'd1, 3'd4, INCR, 0, -1);
        rd_burst(32'h300, 8'd1, 3'd4, INCR, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
